ro_pair_sequencer: RTL and testbench

- Controller for the ring-oscillator PUF datapath.
- Drives the select lines of two 16-to-1 oscillator multiplexers (A and B) to step through NUM_BITS oscillator pairs.
- For each pair, counts rising edges of both mux outputs over a fixed window and compares the counts, producing one response bit.
- Sits between the challenge/response interface and the oscillator mux bank.

---
 rtl/ro_pair_sequencer.sv | 108 ++++++++++
 tb/tb_ro_pair_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ro_pair_sequencer.sv
// ro_pair_sequencer: steps two 16:1 RO muxes through NUM_BITS pairs, counts edges per window, emits one response bit per pair
// Ports: clk/rst_n (async active-low), start+seed (challenge request, accepted in IDLE),
//   mux_a_out/mux_b_out (asynchronous RO mux outputs), sel_a/sel_b (mux selects),
//   busy, done (one-cycle pulse), resp (bit i = pair i).
// Optional: define PUF_TIE_FLAG_EN to add tie_mask (bit i set when pair i counted equal).
module ro_pair_sequencer #(
  parameter int NUM_BITS = 8,
  parameter int SETTLE   = 16,
  parameter int WINDOW   = 1024,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          seed,
  input  logic                mux_a_out,
  input  logic                mux_b_out,
  output logic [3:0]          sel_a,
  output logic [3:0]          sel_b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] resp
`ifdef PUF_TIE_FLAG_EN
  ,
  output logic [NUM_BITS-1:0] tie_mask
`endif
);
  localparam int TW = $clog2(SETTLE + WINDOW + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_COMPARE, S_DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [3:0] seed_q, idx, sel_base;
  logic [2:0] sync_a, sync_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic rise_a, rise_b, last, accept, timer_zero;
  // bits [1:0] are the synchronizer, bit [2] holds the previous synchronized value
  assign rise_a = sync_a[1] & ~sync_a[2];
  assign rise_b = sync_b[1] & ~sync_b[2];
  assign last = idx == 4'(NUM_BITS - 1);
  assign accept = state == S_IDLE && start;
  assign timer_zero = timer == '0;
  // select base for the next pair: seed + 2*(idx+1), 4-bit wrap
  assign sel_base = seed_q + {idx[2:0] + 3'd1, 1'b0};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = start ? S_SETTLE : S_IDLE;
      S_SETTLE:  state_n = timer_zero ? S_COUNT : S_SETTLE;
      S_COUNT:   state_n = timer_zero ? S_COMPARE : S_COUNT;
      S_COMPARE: state_n = last ? S_DONE : S_SETTLE;
      default:   state_n = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state == S_SETTLE || state == S_COUNT || state == S_COMPARE;
    done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      timer  <= '0;
      seed_q <= '0;
      idx    <= '0;
      sel_a  <= '0;
      sel_b  <= '0;
      resp   <= '0;
`ifdef PUF_TIE_FLAG_EN
      tie_mask <= '0;
`endif
    end else begin
      sync_a <= {sync_a[1:0], mux_a_out};
      sync_b <= {sync_b[1:0], mux_b_out};
      // counters only run inside the window and saturate at all-ones
      cnt_a <= state == S_COUNT ? cnt_a + CNT_W'(rise_a & ~&cnt_a) : '0;
      cnt_b <= state == S_COUNT ? cnt_b + CNT_W'(rise_b & ~&cnt_b) : '0;
      timer <= (accept || (state == S_COMPARE && !last)) ? TW'(SETTLE - 1) :
               (state == S_SETTLE && timer_zero) ? TW'(WINDOW - 1) :
               timer - TW'(!timer_zero);
      if (accept) begin
        seed_q <= seed;
        idx    <= '0;
        resp   <= '0;
        sel_a  <= seed;
        sel_b  <= seed + 4'd1;
`ifdef PUF_TIE_FLAG_EN
        tie_mask <= '0;
`endif
      end
      if (state == S_COMPARE) begin
        resp <= resp | (NUM_BITS'(cnt_a > cnt_b) << idx);
`ifdef PUF_TIE_FLAG_EN
        tie_mask <= tie_mask | (NUM_BITS'(cnt_a == cnt_b) << idx);
`endif
        if (!last) begin
          idx   <= idx + 4'd1;
          sel_a <= sel_base;
          sel_b <= sel_base + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ro_pair_sequencer.sv
// tb_ro_pair_sequencer: scoreboard bench with a 16-oscillator model driving two sequencer instances
module tb_ro_pair_sequencer;
  localparam int NB = 4, ST = 2, WIN = 32;
  logic clk = 0, rst_n = 0;
  logic start = 0, start2 = 0;
  logic [3:0] seed = 0, seed2 = 0;
  logic [3:0] sel_a, sel_b, sel_a2, sel_b2;
  logic busy, done, busy2, done2;
  logic [NB-1:0] resp, resp2;
`ifdef PUF_TIE_FLAG_EN
  logic [NB-1:0] tie_mask, tie_mask2;
`endif
  logic [15:0] ro = '0;
  int h[16];
  int hv[4] = '{0, 1, 2, 4};
  int gcyc = 0, cyc = 0, tests = 0, fails = 0;
  logic [7:0] pq[$];
  logic [2*NB-1:0] rq[$], sq[$];
  always #5 clk = ~clk;
  ro_pair_sequencer #(.NUM_BITS(NB), .SETTLE(ST), .WINDOW(WIN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .mux_a_out(ro[sel_a]), .mux_b_out(ro[sel_b]),
    .sel_a(sel_a), .sel_b(sel_b), .busy(busy), .done(done), .resp(resp)
`ifdef PUF_TIE_FLAG_EN
    , .tie_mask(tie_mask)
`endif
  );
  ro_pair_sequencer #(.NUM_BITS(NB), .SETTLE(ST), .WINDOW(WIN), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2),
    .mux_a_out(ro[sel_a2]), .mux_b_out(ro[sel_b2]),
    .sel_a(sel_a2), .sel_b(sel_b2), .busy(busy2), .done(done2), .resp(resp2)
`ifdef PUF_TIE_FLAG_EN
    , .tie_mask(tie_mask2)
`endif
  );
  // oscillators share one time base, so equal half-periods give identical waveforms; h=0 is a stopped RO
  always @(negedge clk) begin
    gcyc++;
    for (int k = 0; k < 16; k++) ro[k] = (h[k] == 0) ? 1'b0 : 1'((gcyc / h[k]) % 2);
  end
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int edges(input int hp, input int mx);
    int n;
    n = (hp == 0) ? 0 : WIN / (2 * hp);
    return n > mx ? mx : n;
  endfunction
  task automatic push_expect(input logic [3:0] s, input bit sat);
    logic [3:0] a, b;
    logic [NB-1:0] r, t;
    int ca, cb;
    for (int i = 0; i < NB; i++) begin
      a = s + 4'(2 * i);
      b = a + 4'd1;
      ca = edges(h[a], sat ? 7 : 65535);
      cb = edges(h[b], sat ? 7 : 65535);
      r[i] = ca > cb;
      t[i] = ca == cb;
      if (!sat) pq.push_back({a, b});
    end
    if (sat) sq.push_back({t, r});
    else rq.push_back({t, r});
  endtask
  task automatic run(input logic [3:0] s, input bit sat);
    bit seen = 0;
    push_expect(s, sat);
    @(negedge clk);
    if (sat) begin start2 = 1; seed2 = s; end
    else begin start = 1; seed = s; end
    @(negedge clk);
    start = 0;
    start2 = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (sat ? done2 : done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    @(negedge clk);
  endtask
  int t0 = 0, bcnt = 0;
  logic pbusy = 0;
  logic [7:0] psel = 0, ep;
  logic [2*NB-1:0] er;
  always @(negedge clk) begin
    if (!rst_n) pbusy = 0;
    else begin
      if (busy && (!pbusy || {sel_a, sel_b} != psel)) begin
        if (!pbusy) begin t0 = cyc; bcnt = 0; end
        if (pq.size() == 0) chk("sel_unexpected", {sel_a, sel_b}, -1);
        else begin ep = pq.pop_front(); chk("sel_pair", {sel_a, sel_b}, ep); end
      end
      if (busy) bcnt++;
      if (done) begin
        if (rq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          er = rq.pop_front();
          chk("resp", resp, er[NB-1:0]);
`ifdef PUF_TIE_FLAG_EN
          chk("tie_mask", tie_mask, er[2*NB-1:NB]);
`endif
          chk("latency", cyc - t0, NB * (ST + WIN + 1));
          chk("busy_cycles", bcnt, NB * (ST + WIN + 1));
          chk("busy_on_done", busy, 0);
          chk("pairs_left", pq.size(), 0);
        end
      end
      if (done2) begin
        if (sq.size() == 0) chk("sat_done_unexpected", 1, 0);
        else begin
          er = sq.pop_front();
          chk("sat_resp", resp2, er[NB-1:0]);
`ifdef PUF_TIE_FLAG_EN
          chk("sat_tie_mask", tie_mask2, er[2*NB-1:NB]);
`endif
        end
      end
      pbusy = busy;
      psel = {sel_a, sel_b};
    end
  end
  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_resp"}, resp, 0);
    chk({tag, "_sel"}, {sel_a, sel_b}, 0);
    chk({tag, "_sat_resp"}, resp2, 0);
`ifdef PUF_TIE_FLAG_EN
    chk({tag, "_tie"}, tie_mask, 0);
`endif
  endtask
  task automatic basic_h();
    for (int k = 0; k < 16; k++) h[k] = (k % 2 == 0) ? 2 : 4;
  endtask
  initial begin
    logic [3:0] s, a;
    for (int k = 0; k < 16; k++) h[k] = 0;
    repeat (3) @(negedge clk);
    #1 reset_checks("reset");
    rst_n = 1;
    basic_h();
    run(4'd0, 0);
    for (int k = 0; k < 16; k++) h[k] = (k == 0) ? 1 : 0;
    run(4'd15, 0);
    for (int k = 0; k < 16; k++) h[k] = 2;
    run(4'd5, 0);
    basic_h();
    fork
      run(4'd3, 0);
      begin
        repeat (45) @(negedge clk);
        start = 1;
        seed = 4'd7;
        @(negedge clk);
        start = 0;
      end
    join
    push_expect(4'd11, 0);
    @(negedge clk);
    start = 1;
    seed = 4'd11;
    @(negedge clk);
    start = 0;
    repeat (80) @(negedge clk);
    rst_n = 0;
    #1 reset_checks("midrst");
    pq.delete();
    rq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    run(4'd9, 0);
    for (int k = 0; k < 16; k++) h[k] = 2;
    run(4'd0, 1);
    for (int r = 0; r < 4; r++) begin
      s = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) h[k] = hv[$urandom_range(0, 3)];
      for (int i = 0; i < NB; i++) begin
        a = s + 4'(2 * i);
        while (h[a + 4'd1] == h[a]) h[a + 4'd1] = hv[$urandom_range(0, 3)];
      end
      run(s, 0);
    end
    repeat (5) @(negedge clk);
    chk("pending", pq.size() + rq.size() + sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
